// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin two-port front end that sequences the single-port RAM control strobes
//   clk_i/rst_ni          clock, async active-low reset
//   req*_i/we*_i          request and direction (1 = write), held until ack
//   addr*_i/wdata*_i      word address and write data, stable while req is high
//   ack*_o                one-cycle completion pulse per port
//   rdata_o               last read result, held until the next read
//   busy_o                high whenever the sequencer is not idle
//   mem_*_o/mem_dbus_io   RAM strobes, address bus and shared data bus
module mem_access_arbiter #(
    parameter int WORD_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req0_i,
    input  logic                     req1_i,
    input  logic                     we0_i,
    input  logic                     we1_i,
    input  logic [ADDRESS_WIDTH-1:0] addr0_i,
    input  logic [ADDRESS_WIDTH-1:0] addr1_i,
    input  logic [WORD_WIDTH-1:0]    wdata0_i,
    input  logic [WORD_WIDTH-1:0]    wdata1_i,
    output logic                     ack0_o,
    output logic                     ack1_o,
    output logic [WORD_WIDTH-1:0]    rdata_o,
    output logic                     busy_o,
    output logic                     mem_ain_o,
    output logic                     mem_din_o,
    output logic                     mem_dout_o,
    output logic                     mem_read_o,
    output logic                     mem_write_o,
    output logic [ADDRESS_WIDTH-1:0] mem_abus_o,
    inout  wire  [WORD_WIDTH-1:0]    mem_dbus_io
);
    typedef enum logic [2:0] {IDLE, ADDR, LOAD, WRITE, READ, XFER, ACK} state_t;
    state_t                   state_q, state_d;
    logic                     gnt_q, gnt_d, we_q, we_d, ptr_q, ptr_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d, abus_q, abus_d;
    logic [WORD_WIDTH-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;
    logic                     ack0_q, ack1_q, busy_q, ain_q, din_q, dout_q, read_q, write_q;
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: if (req0_i || req1_i) begin
                // ptr_q names the port that did not win last time
                gnt_d   = (req0_i && req1_i) ? ptr_q : req1_i;
                we_d    = gnt_d ? we1_i : we0_i;
                addr_d  = gnt_d ? addr1_i : addr0_i;
                wdata_d = gnt_d ? wdata1_i : wdata0_i;
                ptr_d   = ~gnt_d;
                state_d = ADDR;
            end
            ADDR:    state_d = we_q ? LOAD : READ;
            LOAD:    state_d = WRITE;
            WRITE:   state_d = ACK;
            READ:    state_d = XFER;
            XFER:    state_d = ACK;
            default: state_d = IDLE;
        endcase
        // outputs are registered, so they are decoded from the state being entered
        abus_d  = (state_d == ADDR) ? addr_d : '0;
        rdata_d = (state_q == XFER) ? mem_dbus_io : rdata_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ptr_q   <= 1'b0;
            abus_q  <= '0;
            rdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            ain_q   <= 1'b0;
            din_q   <= 1'b0;
            dout_q  <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
            abus_q  <= abus_d;
            rdata_q <= rdata_d;
            ack0_q  <= (state_d == ACK) && !gnt_d;
            ack1_q  <= (state_d == ACK) && gnt_d;
            busy_q  <= state_d != IDLE;
            ain_q   <= state_d == ADDR;
            din_q   <= state_d == LOAD;
            dout_q  <= state_d == XFER;
            read_q  <= state_d == READ;
            write_q <= state_d == WRITE;
        end
    end
    assign mem_dbus_io = din_q ? wdata_q : 'z;
    assign ack0_o      = ack0_q;
    assign ack1_o      = ack1_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = busy_q;
    assign mem_ain_o   = ain_q;
    assign mem_din_o   = din_q;
    assign mem_dout_o  = dout_q;
    assign mem_read_o  = read_q;
    assign mem_write_o = write_q;
    assign mem_abus_o  = abus_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed bench with a small RAM model on the shared bus
module tb_mem_access_arbiter;
    localparam int WW = 8;
    localparam int AW = 5;
    logic          clk = 1'b0, rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [WW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, busy, ain, din, dout, rd, wr;
    logic [WW-1:0] rdata;
    logic [AW-1:0] abus;
    tri0  [WW-1:0] dbus;
    int            n_chk = 0, n_pass = 0;
    logic [WW-1:0] ram [32];
    logic [AW-1:0] ra;
    logic [WW-1:0] rs, rq;

    mem_access_arbiter #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .ack0_o(ack0), .ack1_o(ack1), .rdata_o(rdata), .busy_o(busy),
        .mem_ain_o(ain), .mem_din_o(din), .mem_dout_o(dout),
        .mem_read_o(rd), .mem_write_o(wr), .mem_abus_o(abus), .mem_dbus_io(dbus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ain) ra <= abus;
        if (din) rs <= dbus;
        if (wr) ram[ra] <= rs;
        if (rd) rq <= ram[ra];
    end
    assign dbus = dout ? rq : 'z;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic nc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        chk("din_and_dout", int'(din && dout), 0);
        chk("read_and_write", int'(rd && wr), 0);
        if (!din && !dout) chk("dbus_idle", int'(dbus), 0);
    end

    initial begin
        nc(2);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        chk("rst_strobes", {ain, din, dout, rd, wr}, 0);
        rst_n = 1'b1;
        // port 0 write 0x03 <- A5
        @(posedge clk); #1;
        req0 = 1; we0 = 1; addr0 = 5'h03; wdata0 = 8'hA5;
        nc(1); chk("wr_c0_busy", busy, 0);
        nc(1); chk("wr_c1_ain", ain, 1); chk("wr_c1_abus", abus, 5'h03); chk("wr_c1_busy", busy, 1);
        nc(1); chk("wr_c2_din", din, 1); chk("wr_c2_dbus", dbus, 8'hA5);
        nc(1); chk("wr_c3_write", wr, 1); chk("wr_c3_ack0", ack0, 0);
        nc(1); chk("wr_c4_ack0", ack0, 1); chk("wr_c4_ack1", ack1, 0); req0 = 0;
        nc(1); chk("wr_c5_ack0", ack0, 0); chk("wr_c5_busy", busy, 0);
        // port 0 read 0x03
        @(posedge clk); #1;
        req0 = 1; we0 = 0; addr0 = 5'h03;
        nc(2); chk("rd_c1_ain", ain, 1);
        nc(1); chk("rd_c2_read", rd, 1); chk("rd_c2_din", din, 0);
        nc(1); chk("rd_c3_dout", dout, 1);
        nc(1); chk("rd_c4_ack0", ack0, 1); chk("rd_c4_rdata", rdata, 8'hA5); req0 = 0;
        nc(1); chk("rd_c5_busy", busy, 0);
        // reset during LOAD abandons the write
        @(posedge clk); #1;
        req0 = 1; we0 = 1; addr0 = 5'h0A; wdata0 = 8'h5A;
        nc(3); chk("rs_c2_din", din, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_din", din, 0);
        chk("rs_busy", busy, 0);
        chk("rs_strobes", {ain, din, dout, rd, wr, ack0, ack1}, 0);
        chk("rs_abus", abus, 0);
        chk("rs_rdata", rdata, 0);
        chk("rs_dbus", dbus, 0);
        req0 = 0;
        nc(2); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nc(1); chk("rs_no_ack", {ack0, ack1}, 0); chk("rs_idle", busy, 0);
        end
        // both ports held: port 0 reads 0x03, port 1 writes 0x07 <- 3C
        @(posedge clk); #1;
        req0 = 1; we0 = 0; addr0 = 5'h03;
        req1 = 1; we1 = 1; addr1 = 5'h07; wdata1 = 8'h3C;
        nc(1);
        for (int i = 1; i <= 20; i++) begin
            nc(1);
            chk($sformatf("rr_ack0_c%0d", i), ack0, int'(i == 4 || i == 14));
            chk($sformatf("rr_ack1_c%0d", i), ack1, int'(i == 9 || i == 19));
            if (i == 9 || i == 14) chk($sformatf("rr_rdata_c%0d", i), rdata, 8'hA5);
            if (i == 19) begin req0 = 0; req1 = 0; end
        end
        // port 1 reads 0x07; port 0 raised mid-transaction waits for the next IDLE
        @(posedge clk); #1;
        req1 = 1; we1 = 0; addr1 = 5'h07;
        nc(1);
        for (int i = 1; i <= 10; i++) begin
            nc(1);
            chk($sformatf("late_ack0_c%0d", i), ack0, int'(i == 9));
            chk($sformatf("late_ack1_c%0d", i), ack1, int'(i == 4));
            if (i == 2) begin req0 = 1; we0 = 0; addr0 = 5'h03; end
            if (i == 4) begin chk("late_rdata1", rdata, 8'h3C); req1 = 0; end
            if (i == 9) begin chk("late_rdata0", rdata, 8'hA5); req0 = 0; end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
